blinky_rgb: RTL and testbench

- Free-running RGB LED sequencer for the UPduino board.
- An N-bit prescaler divides the system clock and produces a one-cycle tick every 2^N clocks.
- Each tick advances a 3-bit colour phase. The phase drives the three active-low LED outputs directly, so the LEDs step through all 8 RGB combinations.
- Sits at board top level, between the oscillator clock and the LED pins.

---
 rtl/blinky_rgb.sv | 35 +++
 tb/tb_blinky_rgb.sv | 92 +++++++++
 2 files changed

// File: rtl/blinky_rgb.sv
// blinky_rgb: free-running RGB LED colour sequencer; BLINKY_RGB_PWM_EN dims lit LEDs to 25% duty
module blinky_rgb #(
  parameter int N = 24,
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic reset,
  output logic led_blue,
  output logic led_green,
  output logic led_red
);
  localparam logic [2:0] OFF = (ACTIVE_LOW != 0) ? 3'b111 : 3'b000;
  logic [N-1:0] prescaler;
  logic [2:0] phase;
  logic [2:0] lit;
  logic tick;
  assign tick = &prescaler;
  // prescaler free-runs and wraps; phase advances once per prescaler wrap
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      prescaler <= '0;
      phase <= '0;
    end else begin
      prescaler <= prescaler + N'(1);
      phase <= phase + {2'b00, tick};
    end
`ifdef BLINKY_RGB_PWM_EN
  // lit LEDs are only driven on one prescaler slot in four
  always_comb lit = (prescaler[1:0] == 2'b00) ? phase : 3'b000;
`else
  // each LED follows one phase bit directly
  always_comb lit = phase;
`endif
  assign {led_red, led_green, led_blue} = lit ^ OFF;
endmodule

// File: tb/tb_blinky_rgb.sv
// tb_blinky_rgb: randomized self-checking bench for blinky_rgb against a cycle-count model
module tb_blinky_rgb;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic b0, g0, r0, b1, g1, r1;
  int k = 0;
  int errors = 0;
  int checks = 0;

  blinky_rgb #(.N(4), .ACTIVE_LOW(1)) dut_lo (
    .clk(clk), .reset(reset), .led_blue(b0), .led_green(g0), .led_red(r0)
  );
  blinky_rgb #(.N(4), .ACTIVE_LOW(0)) dut_hi (
    .clk(clk), .reset(reset), .led_blue(b1), .led_green(g1), .led_red(r1)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] model(input int cyc, input bit al);
    int ph;
    int pre;
    logic [2:0] lit;
    ph = (cyc / 16) % 8;
    pre = cyc % 16;
    lit = 3'(ph);
`ifdef BLINKY_RGB_PWM_EN
    if (pre % 4 != 0) lit = 3'b000;
`endif
    return al ? ~lit : lit;
  endfunction

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got rgb=%b expected rgb=%b at %0t", tag, k, got, exp, $time);
    end
  endtask

  task automatic check_both(input string tag);
    check({tag, "_al1"}, {r0, g0, b0}, model(k, 1'b1));
    check({tag, "_al0"}, {r1, g1, b1}, model(k, 1'b0));
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      #1;
      k = reset ? k + 1 : 0;
      check_both(tag);
    end
  endtask

  task automatic async_reset(input int dly, input string tag);
    #(dly);
    reset = 1'b0;
    #1;
    k = 0;
    check({tag, "_al1"}, {r0, g0, b0}, 3'b111);
    check({tag, "_al0"}, {r1, g1, b1}, 3'b000);
  endtask

  task automatic release_reset();
    #3;
    reset = 1'b1;
  endtask

  initial begin
    run(4, "reset_hold");
    release_reset();
    run(15, "pre_step");
    run(1, "first_step");
    run(112, "sequence");
    run(20, "wrap");
    while (k % 128 != 80) run(1, "to_phase5");
    check("phase5_al1", {r0, g0, b0}, model(80, 1'b1));
    async_reset(3, "midrun_reset");
    run(2, "held");
    release_reset();
    run(16, "after_midrun");
    run(40, "phase3_region");
    for (int i = 0; i < 8; i++) begin
      run($urandom_range(1, 300), "rand_run");
      async_reset($urandom_range(1, 7), "rand_reset");
      run($urandom_range(1, 3), "rand_held");
      release_reset();
    end
    run(130, "final_run");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
